dwt_window: RTL and testbench

Parametrised sliding-window generator for the DWT lifting datapath and the successor to the fixed two-pixel pair buffer. Samples stream in one per handshake. They are collected into even/odd pairs, and each completed pair shifts a LEN-tap window by two. The block emits one window per pair over a valid/ready interface, with padding at both line edges and a flush of the right-edge windows after each line. CH channels (e.g. colour planes) share all control and are windowed in lockstep.

---
 rtl/dwt_pkg.sv | 25 ++
 rtl/dwt_window_if.sv | 29 ++
 rtl/dwt_window_lane.sv | 67 ++++++
 rtl/dwt_window.sv | 126 ++++++++++++
 tb/tb_dwt_window.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dwt_pkg.sv
// Shared definitions for the dwt_window sliding-window generator.
//   state_t      : line-level control state (RUN accepts samples, FLUSH pads out the right edge)
//   flush_count  : extra right-edge windows emitted per line for a given LEN
//   edge_rep     : pad-select helper; 1 when pads replicate the line's edge samples
// Build option: DWT_WINDOW_EDGE_REP_EN selects edge replication instead of zero padding.
package dwt_pkg;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  function automatic int unsigned flush_count(input int unsigned len);
    return (len - 2) / 2;
  endfunction

  function automatic logic edge_rep();
`ifdef DWT_WINDOW_EDGE_REP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

endpackage

// File: rtl/dwt_window_if.sv
// Handshake bundle for dwt_window.
//   in_valid/in_ready/in_data/in_last      : sample stream, one sample per channel
//   out_valid/out_ready/out_data/out_first/out_last : window stream
// master: producer of samples and consumer of windows. slave: the window block.
interface dwt_window_if #(
  parameter int unsigned BW  = 8,
  parameter int unsigned LEN = 4,
  parameter int unsigned CH  = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CH*BW-1:0]      in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*LEN*BW-1:0]  out_data;
  logic                  out_first;
  logic                  out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/dwt_window_lane.sv
// One channel of dwt_window: pair register, LEN-tap shift array, last-sample register.
//   clock, reset_n : clock and asynchronous active-low reset
//   hold_en        : even sample accepted, pair not complete -> hold it
//   pair_en        : pair completes from the input -> shift window by two
//   pad_odd        : pair completes on an even in_last sample; odd slot is padded
//   line_start     : the completing pair is the first of its line (left padding)
//   flush_en       : shift a pad pair in after the line has ended
//   last_en        : the line's last sample is being accepted
//   sample         : this channel's input sample
//   window         : taps packed, tap 0 (oldest) in the low bits
// Pad values come from dwt_pkg::edge_rep (macro DWT_WINDOW_EDGE_REP_EN).
module dwt_window_lane
  import dwt_pkg::*;
#(
  parameter int unsigned BW  = 8,
  parameter int unsigned LEN = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              hold_en,
  input  logic              pair_en,
  input  logic              pad_odd,
  input  logic              line_start,
  input  logic              flush_en,
  input  logic              last_en,
  input  logic [BW-1:0]     sample,
  output logic [LEN*BW-1:0] window
);

  logic [BW-1:0] held;
  logic [BW-1:0] last_smp;
  logic [BW-1:0] taps [LEN];
  logic [BW-1:0] ev;
  logic [BW-1:0] od;
  logic [BW-1:0] left_pad;
  logic [BW-1:0] flush_pad;

  // On an odd-length line the even sample arrives live and is also the line's last sample.
  always_comb begin
    ev        = pad_odd ? sample : held;
    od        = pad_odd ? (edge_rep() ? sample : '0) : sample;
    left_pad  = edge_rep() ? ev : '0;
    flush_pad = edge_rep() ? last_smp : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held     <= '0;
      last_smp <= '0;
      for (int unsigned t = 0; t < LEN; t++) taps[t] <= '0;
    end else begin
      if (hold_en) held <= sample;
      if (last_en) last_smp <= sample;
      if (pair_en || flush_en) begin
        for (int unsigned t = 0; t + 2 < LEN; t++)
          taps[t] <= (pair_en && line_start) ? left_pad : taps[t+2];
        taps[LEN-2] <= pair_en ? ev : flush_pad;
        taps[LEN-1] <= pair_en ? od : flush_pad;
      end
    end
  end

  for (genvar t = 0; t < LEN; t++) begin : g_pack
    assign window[t*BW +: BW] = taps[t];
  end

endmodule

// File: rtl/dwt_window.sv
// Sliding-window generator: pairs incoming samples and emits one LEN-tap window per pair,
// with left-edge padding, odd-line padding and a right-edge flush after each line.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : in_valid/in_ready/in_data/in_last sample stream,
//                    out_valid/out_ready/out_data/out_first/out_last window stream
// Parameters BW (sample bits), LEN (even taps >= 2), CH (lockstep channels).
// Build option: DWT_WINDOW_EDGE_REP_EN replicates edge samples instead of zero padding.
module dwt_window
  import dwt_pkg::*;
#(
  parameter int unsigned BW  = 8,
  parameter int unsigned LEN = 4,
  parameter int unsigned CH  = 1
) (
  input logic         clock,
  input logic         reset_n,
  dwt_window_if.slave bus
);

  localparam int unsigned NF = flush_count(LEN);
  localparam int unsigned CW = (NF == 0) ? 1 : $clog2(NF + 1);

  state_t        state, state_next;
  logic          parity;
  logic          ready_en;
  logic          line_start;
  logic          out_valid_r;
  logic          out_first_r;
  logic          out_last_r;
  logic [CW-1:0] flush_cnt;
  logic          can_load;
  logic          hold_en;
  logic          pair_en;
  logic          pad_odd;
  logic          flush_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  // An even sample without in_last never loads the output stage, so it need not
  // wait for the consumer; anything that completes a pair does.
  always_comb begin
    state_next   = state;
    can_load     = !out_valid_r || bus.out_ready;
    bus.in_ready = 1'b0;
    hold_en      = 1'b0;
    pair_en      = 1'b0;
    pad_odd      = 1'b0;
    flush_en     = 1'b0;
    case (state)
      RUN: begin
        bus.in_ready = ready_en && ((!parity && !bus.in_last) || can_load);
        if (bus.in_valid && bus.in_ready) begin
          if (parity || bus.in_last) begin
            pair_en = 1'b1;
            pad_odd = !parity;
            if (bus.in_last && NF != 0) state_next = FLUSH;
          end else begin
            hold_en = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (out_valid_r && bus.out_ready) begin
          if (flush_cnt != '0) flush_en = 1'b1;
          else                 state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en    <= 1'b0;
      parity      <= 1'b0;
      line_start  <= 1'b1;
      out_valid_r <= 1'b0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
      flush_cnt   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (hold_en) parity <= 1'b1;
      if (pair_en) begin
        parity      <= 1'b0;
        line_start  <= bus.in_last;
        out_valid_r <= 1'b1;
        out_first_r <= line_start;
        out_last_r  <= bus.in_last && (NF == 0);
        flush_cnt   <= CW'(NF);
      end else if (flush_en) begin
        flush_cnt   <= flush_cnt - 1'b1;
        out_first_r <= 1'b0;
        out_last_r  <= (flush_cnt == CW'(1));
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_first = out_first_r;
  assign bus.out_last  = out_last_r;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    dwt_window_lane #(
      .BW  (BW),
      .LEN (LEN)
    ) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .hold_en    (hold_en),
      .pair_en    (pair_en),
      .pad_odd    (pad_odd),
      .line_start (line_start),
      .flush_en   (flush_en),
      .last_en    (pair_en && bus.in_last),
      .sample     (bus.in_data[c*BW +: BW]),
      .window     (bus.out_data[c*LEN*BW +: LEN*BW])
    );
  end

endmodule

// File: tb/tb_dwt_window.sv
// Directed bench for dwt_window (BW=8, LEN=4, CH=2; channel 1 carries channel 0 + 10).
// Expected windows come from a padded-sequence model: each line is extended with its
// pads and window k is the LEN samples starting at 2k.
`timescale 1ns/1ps
module tb_dwt_window;
  localparam int BW  = 8;
  localparam int LEN = 4;
  localparam int CH  = 2;
  localparam int NF  = (LEN - 2) / 2;
`ifdef DWT_WINDOW_EDGE_REP_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    logic [63:0] d;
    logic        f;
    logic        l;
  } win_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic man_rdy = 1'b1;
  logic rnd = 1'b1;
  logic rand_mode = 1'b0;
  int   checks = 0;
  int   failures = 0;
  win_t expq[$];
  logic [63:0] got[$];

  always #5 clock = ~clock;

  dwt_window_if #(.BW(BW), .LEN(LEN), .CH(CH)) bus ();

  dwt_window #(.BW(BW), .LEN(LEN), .CH(CH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.out_ready = rand_mode ? rnd : man_rdy;

  initial forever begin
    @(posedge clock);
    #1 rnd = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic [63:0] exp);
    logic [63:0] g;
    g = 'x;
    if (idx < got.size()) g = got[idx];
    check(name, g, exp);
  endtask

  // Model: pad the line, then slide a LEN window by two.
  task automatic model_line(input int base, input int n);
    int   pad [CH][48];
    int   m;
    int   nw;
    win_t w;
    nw = (n + 1) / 2 + NF;
    for (int c = 0; c < CH; c++) begin
      int lp;
      int rp;
      lp = REP ? base + 10 * c : 0;
      rp = REP ? base + n - 1 + 10 * c : 0;
      m = 0;
      for (int i = 0; i < LEN - 2; i++) begin pad[c][m] = lp; m++; end
      for (int i = 0; i < n; i++) begin pad[c][m] = base + i + 10 * c; m++; end
      if (n % 2 == 1) begin pad[c][m] = rp; m++; end
      for (int i = 0; i < LEN - 2; i++) begin pad[c][m] = rp; m++; end
    end
    for (int k = 0; k < nw; k++) begin
      w.d = '0;
      for (int c = 0; c < CH; c++)
        for (int t = 0; t < LEN; t++)
          w.d[(c*LEN+t)*BW +: BW] = 8'(pad[c][2*k+t]);
      w.f = (k == 0);
      w.l = (k == nw - 1);
      expq.push_back(w);
    end
  endtask

  // Drive from posedge+1; acceptance is judged at the negedge before the next edge.
  task automatic send(input int v, input bit last);
    int cyc;
    bit acc;
    cyc = 0;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {8'(v + 10), 8'(v)};
    bus.in_last  = last;
    while (!acc && cyc < 200) begin
      @(negedge clock);
      acc = bus.in_ready;
      @(posedge clock);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_line(input int base, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      send(base + i, i == n - 1);
      if (gap && (i % 2 == 0)) repeat (2) begin @(posedge clock); #1; end
    end
  endtask

  task automatic wait_drain(input int budget, input int nwin);
    int cyc;
    cyc = 0;
    while (expq.size() != 0 && cyc < budget) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("drain", 64'(expq.size()), 64'd0);
    check("window_count", 64'(got.size()), 64'(nwin));
  endtask

  // Compare process: every output handshake against the model, every stall for stability.
  initial begin
    logic [63:0] prev;
    bit pend;
    win_t e;
    pend = 0;
    prev = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          check("hold_valid", 64'(bus.out_valid), 64'd1);
          check("hold_data", bus.out_data, prev);
        end
        if (bus.out_valid && bus.out_ready) begin
          got.push_back(bus.out_data);
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_window actual=%0h required=none", bus.out_data);
          end else begin
            e = expq.pop_front();
            check("win_data", bus.out_data, e.d);
            check("win_first", 64'(bus.out_first), 64'(e.f));
            check("win_last", 64'(bus.out_last), 64'(e.l));
          end
        end
        pend = bus.out_valid && !bus.out_ready;
        prev = bus.out_data;
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_data"}, bus.out_data, 64'd0);
    check({tag, "_out_first"}, 64'(bus.out_first), 64'd0);
    check({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("ready_before_first_clock", 64'(bus.in_ready), 64'd0);
    @(negedge clock);
    check("ready_after_first_clock", 64'(bus.in_ready), 64'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clock);
    reset_checks("reset");
    release_reset();

    // Even line 1..6
    got.delete();
    model_line(1, 6);
    send_line(1, 6, 0);
    wait_drain(50, 4);
    check_got("l1_w0", 0, REP ? 64'h0c0b0b0b_02010101 : 64'h0c0b0000_02010000);
    check_got("l1_w3", 3, REP ? 64'h1010100f_06060605 : 64'h0000100f_00000605);

    // Odd line 1..5
    got.delete();
    model_line(1, 5);
    send_line(1, 5, 0);
    wait_drain(50, 4);
    check_got("odd_w2", 2, REP ? 64'h0f0f0e0d_05050403 : 64'h000f0e0d_00050403);
    check_got("odd_w3", 3, REP ? 64'h0f0f0f0f_05050505 : 64'h0000000f_00000005);

    // Back-pressure on the first window
    got.delete();
    model_line(1, 6);
    man_rdy = 1'b0;
    send(1, 0);
    send(2, 0);
    send(3, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = {8'd14, 8'd4};
    repeat (3) begin
      @(negedge clock);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_data", bus.out_data, REP ? 64'h0c0b0b0b_02010101 : 64'h0c0b0000_02010000);
      @(posedge clock);
      #1;
    end
    man_rdy = 1'b1;
    begin
      bit acc;
      int cyc;
      acc = 0;
      cyc = 0;
      while (!acc && cyc < 20) begin
        @(negedge clock);
        acc = bus.in_ready;
        @(posedge clock);
        #1;
        cyc++;
      end
      check("bp_resume", 64'(acc), 64'd1);
    end
    bus.in_valid = 1'b0;
    send(5, 0);
    send(6, 1);
    wait_drain(50, 4);

    // Reset mid-line with a window parked in the output stage
    man_rdy = 1'b0;
    send(1, 0);
    send(2, 0);
    send(3, 0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_checks("midreset");
    man_rdy = 1'b1;
    release_reset();
    got.delete();
    model_line(7, 4);
    send_line(7, 4, 0);
    wait_drain(50, 3);
    check_got("rst_w0", 0, REP ? 64'h12111111_08070707 : 64'h12110000_08070000);

    // Two-channel line 1..4 / 11..14
    got.delete();
    model_line(1, 4);
    send_line(1, 4, 0);
    wait_drain(50, 3);
    check_got("ch_w0", 0, REP ? 64'h0c0b0b0b_02010101 : 64'h0c0b0000_02010000);
    check_got("ch_w2", 2, REP ? 64'h0e0e0e0d_04040403 : 64'h00000e0d_00000403);

    // Single-sample line
    got.delete();
    model_line(30, 1);
    send_line(30, 1, 0);
    wait_drain(50, 2);

    // Gaps mid-pair with a throttled consumer
    got.delete();
    rand_mode = 1'b1;
    model_line(20, 7);
    send_line(20, 7, 1);
    wait_drain(400, 5);
    rand_mode = 1'b0;

    repeat (4) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
